// File: rtl/arf_rat.sv
// Architectural register file + register alias table.
// Maps each architectural register to the ROB entry of its youngest in-flight
// producer, answers the two dispatch-time source lookups, commits retired
// values and clears mappings whose producer has retired. x0 has no storage.
module arf_rat #(
  parameter int N_ARF    = 32,
  parameter int ARF_ID_W = 5,
  parameter int ROB_ID_W = 5,   // matches the global ROB id width (32-entry ROB)
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_aL,
  input  logic                dispatch_valid,
  input  logic                dispatch_dst_valid,
  input  logic [ARF_ID_W-1:0] dispatch_dst_arf_id,
  input  logic [ROB_ID_W-1:0] dispatch_rob_id,
  input  logic [ARF_ID_W-1:0] src1_arf_id,
  input  logic [ARF_ID_W-1:0] src2_arf_id,
  output logic                src1_renamed,
  output logic                src2_renamed,
  output logic [ROB_ID_W-1:0] src1_rob_id,
  output logic [ROB_ID_W-1:0] src2_rob_id,
  output logic [DATA_W-1:0]   src1_reg_data,
  output logic [DATA_W-1:0]   src2_reg_data,
  input  logic                retire,
  input  logic [ROB_ID_W-1:0] retire_rob_id,
  input  logic [ARF_ID_W-1:0] retire_arf_id,
  input  logic [DATA_W-1:0]   retire_reg_data,
  input  logic                flush
);

  // Entries 1..N_ARF-1 only: x0 is a constant, never a flop.
  logic [N_ARF-1:1][DATA_W-1:0]   arf_data_q, arf_data_d;
  logic [N_ARF-1:1]               rat_valid_q, rat_valid_d;
  logic [N_ARF-1:1][ROB_ID_W-1:0] rat_rob_id_q, rat_rob_id_d;

  logic dispatch_wr;
  logic retire_wr;

  assign dispatch_wr = dispatch_valid & dispatch_dst_valid & ~flush &
                       (dispatch_dst_arf_id != '0);
  assign retire_wr   = retire & (retire_arf_id != '0);

  // Next state: retire commit/clear, then dispatch rename overrides, then flush wipes valids.
  always_comb begin
    arf_data_d   = arf_data_q;
    rat_valid_d  = rat_valid_q;
    rat_rob_id_d = rat_rob_id_q;
    if (retire_wr) begin
      arf_data_d[retire_arf_id] = retire_reg_data;
      // Only the mapping that still names the retiring entry is cleared;
      // a younger producer keeps its mapping.
      if (rat_valid_q[retire_arf_id] && (rat_rob_id_q[retire_arf_id] == retire_rob_id))
        rat_valid_d[retire_arf_id] = 1'b0;
    end
    if (dispatch_wr) begin
      rat_valid_d[dispatch_dst_arf_id]  = 1'b1;
      rat_rob_id_d[dispatch_dst_arf_id] = dispatch_rob_id;
    end
    if (flush)
      rat_valid_d = '0;
  end

  // State registers; async reset clears data, valids and rob ids.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      arf_data_q   <= '0;
      rat_valid_q  <= '0;
      rat_rob_id_q <= '0;
    end else begin
      arf_data_q   <= arf_data_d;
      rat_valid_q  <= rat_valid_d;
      rat_rob_id_q <= rat_rob_id_d;
    end
  end

  // Source lookups straight from current state; same-cycle updates are not bypassed.
  always_comb begin
    src1_renamed  = 1'b0;
    src1_rob_id   = '0;
    src1_reg_data = '0;
    src2_renamed  = 1'b0;
    src2_rob_id   = '0;
    src2_reg_data = '0;
    if (src1_arf_id != '0) begin
      src1_renamed  = rat_valid_q[src1_arf_id];
      src1_rob_id   = rat_rob_id_q[src1_arf_id];
      src1_reg_data = arf_data_q[src1_arf_id];
    end
    if (src2_arf_id != '0) begin
      src2_renamed  = rat_valid_q[src2_arf_id];
      src2_rob_id   = rat_rob_id_q[src2_arf_id];
      src2_reg_data = arf_data_q[src2_arf_id];
    end
  end

endmodule

// File: tb/tb_arf_rat.sv
// Scoreboard bench for arf_rat: driver pushes expected lookups computed from a
// register-level reference model; monitor pops and compares each cycle.
module tb_arf_rat;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_aL = 1'b0;
  logic          dispatch_valid = 1'b0, dispatch_dst_valid = 1'b0;
  logic [4:0]    dispatch_dst_arf_id = '0;
  logic [RW-1:0] dispatch_rob_id = '0;
  logic [4:0]    src1_arf_id = '0, src2_arf_id = '0;
  logic          src1_renamed, src2_renamed;
  logic [RW-1:0] src1_rob_id, src2_rob_id;
  logic [31:0]   src1_reg_data, src2_reg_data;
  logic          retire = 1'b0;
  logic [RW-1:0] retire_rob_id = '0;
  logic [4:0]    retire_arf_id = '0;
  logic [31:0]   retire_reg_data = '0;
  logic          flush = 1'b0;

  arf_rat #(.N_ARF(32), .ARF_ID_W(5), .ROB_ID_W(RW), .DATA_W(32)) dut (
    .clk(clk), .rst_aL(rst_aL),
    .dispatch_valid(dispatch_valid), .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_rob_id(dispatch_rob_id),
    .src1_arf_id(src1_arf_id), .src2_arf_id(src2_arf_id),
    .src1_renamed(src1_renamed), .src2_renamed(src2_renamed),
    .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
    .src1_reg_data(src1_reg_data), .src2_reg_data(src2_reg_data),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: plain per-register arrays.
  logic [31:0]   m_data  [32];
  logic          m_valid [32];
  logic [RW-1:0] m_rob   [32];

  typedef struct {
    logic          r1, r2;
    logic [RW-1:0] b1, b2;
    logic [31:0]   d1, d2;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0; m_valid[i] = 1'b0; m_rob[i] = '0;
    end
  endfunction

  // One cycle of stimulus: drive inputs, push the lookup expectation from
  // pre-edge state, then advance the model by the cycle's rules.
  task automatic cyc(input logic rst, input logic dv, input logic ddv, input int da,
                     input int drob, input int s1, input int s2, input logic ret,
                     input int rrob, input int ra, input logic [31:0] rdata, input logic fl);
    exp_t e;
    logic clr;
    @(posedge clk); #1;
    rst_aL = ~rst;
    dispatch_valid = dv; dispatch_dst_valid = ddv;
    dispatch_dst_arf_id = 5'(da); dispatch_rob_id = RW'(drob);
    src1_arf_id = 5'(s1); src2_arf_id = 5'(s2);
    retire = ret; retire_rob_id = RW'(rrob); retire_arf_id = 5'(ra);
    retire_reg_data = rdata; flush = fl;
    if (rst) model_reset();
    e.r1 = (s1 == 0) ? 1'b0 : m_valid[s1];
    e.b1 = (s1 == 0) ? '0   : m_rob[s1];
    e.d1 = (s1 == 0) ? '0   : m_data[s1];
    e.r2 = (s2 == 0) ? 1'b0 : m_valid[s2];
    e.b2 = (s2 == 0) ? '0   : m_rob[s2];
    e.d2 = (s2 == 0) ? '0   : m_data[s2];
    sb.push_back(e);
    if (!rst) begin
      clr = 1'b0;
      if (ret && ra != 0) begin
        m_data[ra] = rdata;
        clr = m_valid[ra] && (m_rob[ra] == RW'(rrob));
      end
      if (clr) m_valid[ra] = 1'b0;
      if (dv && ddv && da != 0 && !fl) begin
        m_valid[da] = 1'b1; m_rob[da] = RW'(drob);
      end
      if (fl) for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    end
  endtask

  task automatic idle(input int s1, input int s2);
    cyc(0, 0, 0, 0, 0, s1, s2, 0, 0, 0, 32'h0, 0);
  endtask

  // Monitor: outputs are always presented; compare one expectation per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("src1_renamed", 32'(src1_renamed), 32'(e.r1));
      chk("src1_rob_id",  32'(src1_rob_id),  32'(e.b1));
      chk("src1_reg_data", src1_reg_data, e.d1);
      chk("src2_renamed", 32'(src2_renamed), 32'(e.r2));
      chk("src2_rob_id",  32'(src2_rob_id),  32'(e.b2));
      chk("src2_reg_data", src2_reg_data, e.d2);
    end
  end

  initial begin
    int da, ra, s1;
    model_reset();
    cyc(1, 0, 0, 0, 0, 5, 31, 0, 0, 0, 32'h0, 0);
    cyc(1, 1, 1, 5, 3, 5, 31, 1, 0, 5, 32'h1234, 0);
    idle(5, 31);
    // Rename then retire (same-cycle retire lookup still sees the mapping)
    cyc(0, 1, 1, 3, 7, 0, 0, 0, 0, 0, 32'h0, 0);
    idle(3, 0);
    cyc(0, 0, 0, 0, 0, 3, 3, 1, 7, 3, 32'hDEAD_BEEF, 0);
    idle(3, 0);
    // Stale retire
    cyc(0, 1, 1, 4, 2, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 4, 5, 4, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 0, 0, 4, 0, 1, 2, 4, 32'h11, 0);
    idle(4, 0);
    // dispatch_dst_valid=0 leaves mapping unchanged
    cyc(0, 1, 0, 4, 9, 4, 0, 0, 0, 0, 32'h0, 0);
    idle(4, 0);
    // Same-cycle retire + dispatch on one register
    cyc(0, 1, 1, 6, 1, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 6, 9, 6, 0, 1, 1, 6, 32'h22, 0);
    idle(6, 0);
    // Flush with squashed dispatch and committed retire
    cyc(0, 1, 1, 8, 3, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 9, 4, 8, 0, 0, 0, 0, 32'h0, 0);
    cyc(0, 1, 1, 10, 6, 8, 9, 1, 0, 12, 32'h33, 1);
    idle(8, 9);
    idle(10, 12);
    // x0 ignores everything
    cyc(0, 1, 1, 0, 2, 0, 0, 1, 2, 0, 32'hFFFF_FFFF, 0);
    idle(0, 0);
    // Randomized traffic with one async reset in the middle
    for (int n = 0; n < 2000; n++) begin
      da = $urandom_range(0, 31);
      ra = $urandom_range(0, 31);
      s1 = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 31);
      cyc(n == 1000, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, da,
          $urandom_range(0, 31), s1, $urandom_range(0, 31), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 1) == 1) ? int'(m_rob[ra]) : $urandom_range(0, 31), ra,
          $urandom(), $urandom_range(0, 31) == 0);
    end
    idle(0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
